// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Fetch-side consumer of the EX-stage redirect interface. Owns the fetch PC
// and each cycle either advances it by 4, holds it, or loads a redirect target.
// Raises the IF/ID and ID/EX flushes so that wrong-path instructions are
// squashed. Runs the halt drain sequence and traps illegal redirect targets.
//
// Operating modes:
//   RUN    : normal fetch. Priority: Halt > illegal redirect > legal redirect
//            > Stall > sequential advance.
//   DRAIN  : entered on Halt. Lets EX/MEM/WB retire for DRAIN_CYC cycles with
//            fetch squashed, then moves to HALTED.
//   HALTED : core stopped. Left only by reset.
//   FAULT  : an illegal redirect target was seen. Left only by reset.
//
// Parameters:
//   PC_W      width of the fetch PC (instruction memory byte address)
//   RESET_PC  PC loaded by reset (4-byte aligned)
//   DRAIN_CYC number of cycles spent in DRAIN
//
// Ports:
//   clk            in   system clock, all state updates on posedge
//   reset          in   synchronous, active-low reset
//   Stall          in   hazard unit: hold PC this cycle
//   PcSel          in   EX: take redirect this cycle
//   BrPC[31:0]     in   EX: redirect target byte address
//   Halt           in   EX: halt instruction reached EX
//   PC[PC_W-1:0]   out  current fetch address
//   PC_Valid       out  fetch slot holds a real instruction (RUN only)
//   Flush_IFID     out  clear IF/ID on next edge (combinational)
//   Flush_IDEX     out  clear ID/EX on next edge (combinational)
//   Halted         out  core stopped after drain (registered)
//   Fault          out  sticky illegal-target indication (registered)
//   RedirectCount  out  accepted redirects, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter int unsigned PC_W      = 9,
    parameter int unsigned RESET_PC  = 0,
    parameter int unsigned DRAIN_CYC = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Stall,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            Halt,
    output logic [PC_W-1:0] PC,
    output logic            PC_Valid,
    output logic            Flush_IFID,
    output logic            Flush_IDEX,
    output logic            Halted,
    output logic            Fault,
    output logic [15:0]     RedirectCount
);

    // Drain counter counts DRAIN_CYC-1 down to 0, so it needs enough bits to
    // hold DRAIN_CYC-1. A DRAIN_CYC of 0 is treated like 1 (single drain cycle).
    localparam int unsigned DRAIN_LOAD = (DRAIN_CYC > 0) ? (DRAIN_CYC - 1) : 0;
    localparam int unsigned CNT_W      = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    localparam logic [PC_W-1:0]  PC_RESET_VAL = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0]  PC_STEP      = PC_W'(4);
    localparam logic [CNT_W-1:0] CNT_LOAD     = CNT_W'(DRAIN_LOAD);
    localparam logic [15:0]      CNT_MAX      = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_HALTED  = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    state_t            state_q,        state_d;
    logic [PC_W-1:0]   pc_q,           pc_d;
    logic [CNT_W-1:0]  drain_cnt_q,    drain_cnt_d;
    logic              halted_q,       halted_d;
    logic              fault_q,        fault_d;
    logic [15:0]       redirect_cnt_q, redirect_cnt_d;

    logic              pc_valid;
    logic              flush;
    logic              target_illegal;

    // A target is illegal if it is not word aligned or if it addresses
    // beyond the PC_W-bit instruction memory. Shifting by PC_W keeps this
    // valid for any PC_W up to 32 (a full-width shift yields zero).
    always_comb begin
        target_illegal = (BrPC[1:0] != 2'b00) || ((BrPC >> PC_W) != 32'd0);
    end

    // Next-state and output decode
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        drain_cnt_d    = drain_cnt_q;
        redirect_cnt_d = redirect_cnt_q;
        pc_valid       = 1'b0;
        flush          = 1'b1;

        case (state_q)
            ST_RUN: begin
                pc_valid = 1'b1;
                flush    = 1'b0;
                if (Halt) begin
                    // Halt wins over a simultaneous redirect; fetch freezes
                    // and the younger stages are squashed while EX onward drains.
                    flush       = 1'b1;
                    state_d     = ST_DRAIN;
                    drain_cnt_d = CNT_LOAD;
                end else if (PcSel) begin
                    flush = 1'b1;
                    if (target_illegal) begin
                        state_d = ST_FAULT;
                    end else begin
                        // A redirect overrides a load-use stall: the stalled
                        // instruction is on the wrong path and gets flushed.
                        pc_d = BrPC[PC_W-1:0];
                        if (redirect_cnt_q != CNT_MAX) begin
                            redirect_cnt_d = redirect_cnt_q + 16'd1;
                        end
                    end
                end else if (!Stall) begin
                    // Natural PC_W-bit overflow gives the required wrap to 0.
                    pc_d = pc_q + PC_STEP;
                end
            end

            ST_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_cnt_d = drain_cnt_q - CNT_W'(1);
                end
            end

            ST_HALTED: begin
                state_d = ST_HALTED;
            end

            ST_FAULT: begin
                state_d = ST_FAULT;
            end

            default: begin
                state_d = ST_FAULT;
            end
        endcase

        // Status flags are registered copies of the destination state so
        // they become visible in the first cycle spent in that state.
        halted_d = (state_d == ST_HALTED);
        fault_d  = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_RUN;
            pc_q           <= PC_RESET_VAL;
            drain_cnt_q    <= '0;
            halted_q       <= 1'b0;
            fault_q        <= 1'b0;
            redirect_cnt_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            drain_cnt_q    <= drain_cnt_d;
            halted_q       <= halted_d;
            fault_q        <= fault_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign PC            = pc_q;
    assign PC_Valid      = pc_valid;
    assign Flush_IFID    = flush;
    assign Flush_IDEX    = flush;
    assign Halted        = halted_q;
    assign Fault         = fault_q;
    assign RedirectCount = redirect_cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//
// Self-checking bench for pc_fetch_ctrl (PC_W=9, RESET_PC=0, DRAIN_CYC=3).
// Directed scenarios cover reset, wrap, redirect-vs-stall, halt drain, fault
// trapping, reset during drain and counter saturation; a randomized run is
// checked cycle by cycle against a behavioural reference model.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;
    localparam int PC_W = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset = 1'b0;
    logic            Stall = 1'b0;
    logic            PcSel = 1'b0;
    logic            Halt  = 1'b0;
    logic [31:0]     BrPC  = 32'd0;
    logic [PC_W-1:0] PC;
    logic            PC_Valid, Flush_IFID, Flush_IDEX, Halted, Fault;
    logic [15:0]     RedirectCount;

    pc_fetch_ctrl #(
        .PC_W      (9),
        .RESET_PC  (0),
        .DRAIN_CYC (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .Stall         (Stall),
        .PcSel         (PcSel),
        .BrPC          (BrPC),
        .Halt          (Halt),
        .PC            (PC),
        .PC_Valid      (PC_Valid),
        .Flush_IFID    (Flush_IFID),
        .Flush_IDEX    (Flush_IDEX),
        .Halted        (Halted),
        .Fault         (Fault),
        .RedirectCount (RedirectCount)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- behavioural reference model ----------------
    bit          m_known      = 1'b0;
    int unsigned m_pc         = 0;
    int unsigned m_count      = 0;
    int          m_drain_left = 0;   // drain cycles still to spend
    bit          m_halted     = 1'b0;
    bit          m_fault      = 1'b0;

    logic [PC_W-1:0] e_pc;
    logic [15:0]     e_count;
    logic            e_valid, e_flush, e_halted, e_fault;

    function automatic bit model_running();
        return !m_halted && !m_fault && (m_drain_left == 0);
    endfunction

    // Expected outputs for the current cycle given the current inputs.
    function automatic void model_expect();
        e_pc     = PC_W'(m_pc);
        e_count  = 16'(m_count);
        e_halted = m_halted;
        e_fault  = m_fault;
        e_valid  = model_running();
        e_flush  = model_running() ? (Halt || PcSel) : 1'b1;
    endfunction

    // Model state update at a rising edge, using the inputs held across it.
    function automatic void model_edge();
        if (reset == 1'b0) begin
            m_known = 1'b1; m_pc = 0; m_count = 0;
            m_drain_left = 0; m_halted = 1'b0; m_fault = 1'b0;
        end else if (model_running()) begin
            if (Halt) begin
                m_drain_left = 3;
            end else if (PcSel) begin
                if ((BrPC % 4) != 0 || BrPC >= 32'd512) m_fault = 1'b1;
                else begin
                    m_pc = BrPC;
                    if (m_count < 65535) m_count = m_count + 1;
                end
            end else if (!Stall) begin
                m_pc = (m_pc + 4) % 512;
            end
        end else if (m_drain_left > 0) begin
            m_drain_left = m_drain_left - 1;
            if (m_drain_left == 0) m_halted = 1'b1;
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit rst_n, input bit st, input bit ps,
                         input bit hl, input logic [31:0] tgt);
        reset = rst_n; Stall = st; PcSel = ps; Halt = hl; BrPC = tgt;
    endtask

    task automatic settle();
        @(negedge clk);
        model_expect();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
    endtask

    // ---------------- T1: reset and sequential fetch ----------------
    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        settle();
        n_checks++; if (PC !== 9'h000) $display("FAIL t1_reset_pc got=%h exp=000", PC); else n_pass++;
        n_checks++; if (Halted !== 1'b0) $display("FAIL t1_reset_halted got=%b exp=0", Halted); else n_pass++;
        n_checks++; if (Fault !== 1'b0) $display("FAIL t1_reset_fault got=%b exp=0", Fault); else n_pass++;
        n_checks++; if (RedirectCount !== 16'd0) $display("FAIL t1_reset_count got=%0d exp=0", RedirectCount); else n_pass++;
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            logic [PC_W-1:0] exp_pc;
            exp_pc = PC_W'(4 * i);
            settle();
            $display("T1 step %0d: PC=%h valid=%b flush=%b/%b", i, PC, PC_Valid, Flush_IFID, Flush_IDEX);
            n_checks++; if (PC !== exp_pc) $display("FAIL t1_pc step=%0d got=%h exp=%h", i, PC, exp_pc); else n_pass++;
            n_checks++; if (PC_Valid !== 1'b1) $display("FAIL t1_valid step=%0d got=%b exp=1", i, PC_Valid); else n_pass++;
            n_checks++; if ({Flush_IFID, Flush_IDEX} !== 2'b00) $display("FAIL t1_flush step=%0d got=%b%b exp=00", i, Flush_IFID, Flush_IDEX); else n_pass++;
            tick();
        end
    endtask

    // ---------------- T2: PC wrap ----------------
    task automatic test_wrap();
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h1FC);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        settle();
        n_checks++; if (PC !== 9'h1FC) $display("FAIL t2_pc_top got=%h exp=1fc", PC); else n_pass++;
        tick();
        settle();
        $display("T2 wrap: PC=%h fault=%b", PC, Fault);
        n_checks++; if (PC !== 9'h000) $display("FAIL t2_pc_wrap got=%h exp=000", PC); else n_pass++;
        n_checks++; if (Fault !== 1'b0) $display("FAIL t2_fault got=%b exp=0", Fault); else n_pass++;
        n_checks++; if (PC_Valid !== 1'b1) $display("FAIL t2_valid got=%b exp=1", PC_Valid); else n_pass++;
        tick();
    endtask

    // ---------------- T3: redirect beats stall ----------------
    task automatic test_redirect_stall();
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h040);
        settle();
        n_checks++; if ({Flush_IFID, Flush_IDEX} !== 2'b11) $display("FAIL t3_flush got=%b%b exp=11", Flush_IFID, Flush_IDEX); else n_pass++;
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        settle();
        $display("T3 redirect+stall: PC=%h count=%0d", PC, RedirectCount);
        n_checks++; if (PC !== 9'h040) $display("FAIL t3_pc got=%h exp=040", PC); else n_pass++;
        n_checks++; if (RedirectCount !== 16'd1) $display("FAIL t3_count got=%0d exp=1", RedirectCount); else n_pass++;
        n_checks++; if ({Flush_IFID, Flush_IDEX} !== 2'b00) $display("FAIL t3_flush_after got=%b%b exp=00", Flush_IFID, Flush_IDEX); else n_pass++;
        tick();
    endtask

    // ---------------- T4: halt drain ----------------
    task automatic test_halt();
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h080);
        settle();
        n_checks++; if ({Flush_IFID, Flush_IDEX} !== 2'b11) $display("FAIL t4_flush_c1 got=%b%b exp=11", Flush_IFID, Flush_IDEX); else n_pass++;
        tick();
        for (int c = 2; c <= 8; c++) begin
            logic [31:0] tgt;
            tgt = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
            drive(1'b1, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), tgt);
            settle();
            $display("T4 cycle %0d: PC=%h valid=%b halted=%b", c, PC, PC_Valid, Halted);
            n_checks++; if (PC !== 9'h000) $display("FAIL t4_pc c=%0d got=%h exp=000", c, PC); else n_pass++;
            n_checks++; if (PC_Valid !== 1'b0) $display("FAIL t4_valid c=%0d got=%b exp=0", c, PC_Valid); else n_pass++;
            n_checks++; if ({Flush_IFID, Flush_IDEX} !== 2'b11) $display("FAIL t4_flush c=%0d got=%b%b exp=11", c, Flush_IFID, Flush_IDEX); else n_pass++;
            n_checks++; if (Halted !== (c >= 5)) $display("FAIL t4_halted c=%0d got=%b exp=%b", c, Halted, (c >= 5)); else n_pass++;
            n_checks++; if (RedirectCount !== 16'd0) $display("FAIL t4_count c=%0d got=%0d exp=0", c, RedirectCount); else n_pass++;
            tick();
        end
    endtask

    // ---------------- T5: illegal targets ----------------
    task automatic test_fault();
        logic [31:0] bad [3];
        bad[0] = 32'h0000_0042; bad[1] = 32'h0000_0200; bad[2] = 32'h8000_0040;
        for (int k = 0; k < 3; k++) begin
            do_reset();
            drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
            tick();                                   // PC -> 0x004
            drive(1'b1, 1'b0, 1'b1, 1'b0, bad[k]);
            settle();
            n_checks++; if ({Flush_IFID, Flush_IDEX} !== 2'b11) $display("FAIL t5_flush k=%0d got=%b%b exp=11", k, Flush_IFID, Flush_IDEX); else n_pass++;
            n_checks++; if (Fault !== 1'b0) $display("FAIL t5_fault_early k=%0d got=%b exp=0", k, Fault); else n_pass++;
            tick();
            for (int j = 0; j < 2; j++) begin
                drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h040);   // legal, must be ignored
                settle();
                $display("T5 target %h step %0d: PC=%h fault=%b count=%0d", bad[k], j, PC, Fault, RedirectCount);
                n_checks++; if (Fault !== 1'b1) $display("FAIL t5_fault k=%0d j=%0d got=%b exp=1", k, j, Fault); else n_pass++;
                n_checks++; if (PC !== 9'h004) $display("FAIL t5_pc k=%0d j=%0d got=%h exp=004", k, j, PC); else n_pass++;
                n_checks++; if (RedirectCount !== 16'd0) $display("FAIL t5_count k=%0d j=%0d got=%0d exp=0", k, j, RedirectCount); else n_pass++;
                n_checks++; if (PC_Valid !== 1'b0) $display("FAIL t5_valid k=%0d j=%0d got=%b exp=0", k, j, PC_Valid); else n_pass++;
                tick();
            end
        end
    endtask

    // ---------------- T6a: reset during drain ----------------
    task automatic test_reset_in_drain();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
        tick();                                       // -> drain cycle 1
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();                                       // -> drain cycle 2
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
        settle();
        n_checks++; if (PC_Valid !== 1'b0) $display("FAIL t6_drain_valid got=%b exp=0", PC_Valid); else n_pass++;
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        settle();
        $display("T6 reset in drain: PC=%h valid=%b halted=%b", PC, PC_Valid, Halted);
        n_checks++; if (PC !== 9'h000) $display("FAIL t6_pc got=%h exp=000", PC); else n_pass++;
        n_checks++; if (PC_Valid !== 1'b1) $display("FAIL t6_valid got=%b exp=1", PC_Valid); else n_pass++;
        n_checks++; if (Halted !== 1'b0) $display("FAIL t6_halted got=%b exp=0", Halted); else n_pass++;
        tick();
        settle();
        n_checks++; if (PC !== 9'h004) $display("FAIL t6_pc_next got=%h exp=004", PC); else n_pass++;
        tick();
    endtask

    // ---------------- T6b: redirect counter saturation ----------------
    task automatic test_saturate();
        logic [31:0] tgt;
        tgt = 32'd0;
        do_reset();
        for (int i = 1; i <= 65536; i++) begin
            tgt = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
            drive(1'b1, 1'($urandom % 2), 1'b1, 1'b0, tgt);
            tick();
            if (i == 100 || i == 65534 || i == 65535 || i == 65536 || (i % 8192) == 0) begin
                $display("T6 saturation after %0d redirects: count=%0d", i, RedirectCount);
                n_checks++; if (RedirectCount !== 16'(m_count)) $display("FAIL t6_sat_model i=%0d got=%0d exp=%0d", i, RedirectCount, m_count); else n_pass++;
            end
        end
        n_checks++; if (RedirectCount !== 16'hFFFF) $display("FAIL t6_sat_final got=%h exp=ffff", RedirectCount); else n_pass++;
        n_checks++; if (PC !== tgt[PC_W-1:0]) $display("FAIL t6_sat_pc got=%h exp=%h", PC, tgt[PC_W-1:0]); else n_pass++;
    endtask

    // ---------------- randomized run against the model ----------------
    task automatic test_random();
        int errs_before;
        errs_before = n_checks - n_pass;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] tgt;
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 70)      tgt = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
            else if (sel < 85) tgt = {23'd0, 7'($urandom_range(0, 127)), 2'($urandom_range(1, 3))};
            else               tgt = $urandom;
            drive(($urandom % 60) != 0, ($urandom % 3) == 0, ($urandom % 5) == 0,
                  ($urandom % 40) == 0, tgt);
            settle();
            n_checks++; if (PC !== e_pc) $display("FAIL rnd_pc c=%0d got=%h exp=%h", c, PC, e_pc); else n_pass++;
            n_checks++; if (PC_Valid !== e_valid) $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, PC_Valid, e_valid); else n_pass++;
            n_checks++; if (Flush_IFID !== e_flush) $display("FAIL rnd_flush_ifid c=%0d got=%b exp=%b", c, Flush_IFID, e_flush); else n_pass++;
            n_checks++; if (Flush_IDEX !== e_flush) $display("FAIL rnd_flush_idex c=%0d got=%b exp=%b", c, Flush_IDEX, e_flush); else n_pass++;
            n_checks++; if (Halted !== e_halted) $display("FAIL rnd_halted c=%0d got=%b exp=%b", c, Halted, e_halted); else n_pass++;
            n_checks++; if (Fault !== e_fault) $display("FAIL rnd_fault c=%0d got=%b exp=%b", c, Fault, e_fault); else n_pass++;
            n_checks++; if (RedirectCount !== e_count) $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, RedirectCount, e_count); else n_pass++;
            tick();
            if ((c % 500) == 499)
                $display("RND cycles %0d: PC=%h count=%0d halted=%b fault=%b errors=%0d",
                         c + 1, PC, RedirectCount, Halted, Fault, (n_checks - n_pass) - errs_before);
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        test_reset();
        test_wrap();
        test_redirect_stall();
        test_halt();
        test_fault();
        test_reset_in_drain();
        test_random();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
